// File: rtl/leggiero_pkg.sv
// Shared definitions for the Leggiero button front end: BTN1 FSM encoding
// and the default 20 MHz timing constants.
package leggiero_pkg;

   // BTN1 press-tracking FSM states.
   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StHeld     = 2'd1,
      StLongHeld = 2'd2
   } btn1_state_e;

   // Default timing for a 20 MHz CLKA.
   localparam int unsigned DEBOUNCE_1MS = 20000;    // 1 ms stable window
   localparam int unsigned LONG_50MS    = 1000000;  // 50 ms long-press window

   // Width needed to hold the values 0 .. n-1, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button input chain: a 2-FF synchronizer followed by a counting
// debouncer. Reports the debounced level plus registered press/release pulses.
module btn_debounce
   import leggiero_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_1MS
) (
   input  logic clk_i,
   input  logic rst_ni,     // synchronous, active-low
   input  logic btn_ni,     // raw button, asynchronous, active-low
   output logic stable_o,   // debounced level, idles high
   output logic press_o,    // one cycle when stable falls
   output logic release_o   // one cycle when stable rises
);

   localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            stable_q, stable_d;
   logic            press_q, press_d;
   logic            release_q, release_d;
   logic            differ;

   // Count consecutive cycles that the synchronized level disagrees with the
   // accepted level; any agreement restarts the window, so short glitches
   // never produce an event.
   always_comb begin
      cnt_d     = '0;
      stable_d  = stable_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      differ    = (sync2_q != stable_q);
      if (differ) begin
         if (cnt_q >= CntLast) begin
            // Window complete: accept the new level.
            stable_d  = ~stable_q;
            press_d   = stable_q;
            release_d = ~stable_q;
            cnt_d     = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchronizer and debounce state, synchronous reset to the idle-high level.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         cnt_q     <= '0;
         stable_q  <= 1'b1;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= btn_ni;
         sync2_q   <= sync1_q;
         cnt_q     <= cnt_d;
         stable_q  <= stable_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign stable_o  = stable_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/btn_mode_ctrl.sv
// Button front end for the backscatter core. BTN0 steps a wrap-around mode
// index; BTN1 short press toggles tx_en, long press aborts (tx off, mode 0).
// Every output is a flop; no input reaches an output combinationally.
module btn_mode_ctrl
   import leggiero_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_1MS,
   parameter int unsigned LONG_PRESS_CYCLES = LONG_50MS,
   parameter int unsigned NUM_MODES         = 4,
   parameter int unsigned MODE_W            = 2
) (
   input  logic              CLKA,
   input  logic              RSTBTN,    // synchronous, active-low
   input  logic              BTN0,      // mode button, active-low
   input  logic              BTN1,      // transmit button, active-low
   output logic [MODE_W-1:0] mode,
   output logic              mode_chg,
   output logic              tx_en,
   output logic              abort
);

   localparam int unsigned HoldW = cnt_width(LONG_PRESS_CYCLES);
   localparam logic [HoldW-1:0]  HoldLast = HoldW'(LONG_PRESS_CYCLES - 1);
   localparam logic [MODE_W-1:0] ModeLast = MODE_W'(NUM_MODES - 1);

   logic btn0_stable, btn0_press, btn0_release;
   logic btn1_stable, btn1_press, btn1_release;
   logic unused_sigs;

   btn1_state_e       state_q;
   logic [HoldW-1:0]  hold_cnt_q;
   logic [MODE_W-1:0] mode_q;
   logic              mode_chg_q;
   logic              tx_en_q;
   logic              abort_q;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_dbn0 (
      .clk_i     (CLKA),
      .rst_ni    (RSTBTN),
      .btn_ni    (BTN0),
      .stable_o  (btn0_stable),
      .press_o   (btn0_press),
      .release_o (btn0_release)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_dbn1 (
      .clk_i     (CLKA),
      .rst_ni    (RSTBTN),
      .btn_ni    (BTN1),
      .stable_o  (btn1_stable),
      .press_o   (btn1_press),
      .release_o (btn1_release)
   );

   // Levels and the BTN0 release are not needed by the command logic.
   assign unused_sigs = btn0_stable ^ btn1_stable ^ btn0_release;

   // Mode index successor with wrap at NUM_MODES-1.
   function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
      return (m == ModeLast) ? '0 : m + 1'b1;
   endfunction

   // BTN1 FSM, mode counter and registered command outputs.
   always_ff @(posedge CLKA) begin
      if (!RSTBTN) begin
         state_q    <= StIdle;
         hold_cnt_q <= '0;
         mode_q     <= '0;
         mode_chg_q <= 1'b0;
         tx_en_q    <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         mode_chg_q <= 1'b0;
         abort_q    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // BTN1 wins a same-cycle collision; BTN0 is only honoured here.
               if (btn1_press) begin
                  state_q    <= StHeld;
                  hold_cnt_q <= '0;
               end else if (btn0_press) begin
                  mode_q     <= next_mode(mode_q);
                  mode_chg_q <= 1'b1;
               end
            end
            StHeld: begin
               if (hold_cnt_q >= HoldLast) begin
                  state_q    <= StLongHeld;
                  abort_q    <= 1'b1;
                  tx_en_q    <= 1'b0;
                  mode_q     <= '0;
                  mode_chg_q <= (mode_q != '0);
               end else if (btn1_release) begin
                  tx_en_q <= ~tx_en_q;
                  state_q <= StIdle;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            StLongHeld: begin
               // Release after an abort has no further effect.
               if (btn1_release) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign mode     = mode_q;
   assign mode_chg = mode_chg_q;
   assign tx_en    = tx_en_q;
   assign abort    = abort_q;

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// Directed bench for btn_mode_ctrl with short debounce/long-press windows.
`timescale 1ns/1ps
module tb_btn_mode_ctrl;

   localparam int unsigned Dbn  = 16;
   localparam int unsigned Long = 1024;
   // Drive point (just after edge d) to registered effect of a debounced edge.
   localparam int unsigned Lat  = Dbn + 3;

   logic       CLKA = 1'b0;
   logic       RSTBTN;
   logic       BTN0;
   logic       BTN1;
   logic [1:0] mode;
   logic       mode_chg;
   logic       tx_en;
   logic       abort;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int chg_cnt = 0;
   int abort_cnt = 0;
   int last_chg_cyc = -1;
   int last_abort_cyc = -1;
   int last_tx_cyc = -1;
   logic tx_prev = 1'b0;

   int d, r, base_chg, base_ab;

   btn_mode_ctrl #(
      .DEBOUNCE_CYCLES   (Dbn),
      .LONG_PRESS_CYCLES (Long),
      .NUM_MODES         (4),
      .MODE_W            (2)
   ) dut (
      .CLKA     (CLKA),
      .RSTBTN   (RSTBTN),
      .BTN0     (BTN0),
      .BTN1     (BTN1),
      .mode     (mode),
      .mode_chg (mode_chg),
      .tx_en    (tx_en),
      .abort    (abort)
   );

   always #25 CLKA = ~CLKA;

   always @(posedge CLKA) cyc <= cyc + 1;

   // Event log sampled mid-cycle.
   always @(negedge CLKA) begin
      if (mode_chg === 1'b1) begin
         chg_cnt = chg_cnt + 1;
         last_chg_cyc = cyc;
      end
      if (abort === 1'b1) begin
         abort_cnt = abort_cnt + 1;
         last_abort_cyc = cyc;
      end
      if (tx_en !== tx_prev) begin
         tx_prev = tx_en;
         last_tx_cyc = cyc;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge CLKA);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      RSTBTN = 1'b0;
      BTN0   = 1'b1;
      BTN1   = 1'b1;
      wait_cyc(10);
      chk("rst_mode", 32'(mode), 0);
      chk("rst_tx_en", 32'(tx_en), 0);
      chk("rst_mode_chg", 32'(mode_chg), 0);
      chk("rst_abort", 32'(abort), 0);
      RSTBTN = 1'b1;
      wait_cyc(100);
      chk("idle_no_chg", chg_cnt, 0);
      chk("idle_no_abort", abort_cnt, 0);

      // Long BTN0 hold: exactly one event, Lat after the drive point.
      d = cyc;
      BTN0 = 1'b0;
      wait_cyc(1000);
      chk("b0_one_event", chg_cnt, 1);
      chk("b0_event_time", last_chg_cyc, d + Lat);
      chk("b0_mode1", 32'(mode), 1);
      BTN0 = 1'b1;
      wait_cyc(40);
      chk("b0_release_quiet", chg_cnt, 1);

      // Four more presses walk the mode through the wrap.
      for (int i = 0; i < 4; i++) begin
         BTN0 = 1'b0;
         wait_cyc(40);
         BTN0 = 1'b1;
         wait_cyc(40);
         chk("b0_wrap_mode", 32'(mode), (i + 2) % 4);
      end
      chk("b0_wrap_count", chg_cnt, 5);

      // 15-cycle glitches never complete the debounce window.
      base_chg = chg_cnt;
      for (int i = 0; i < 20; i++) begin
         BTN0 = 1'b0;
         wait_cyc(15);
         BTN0 = 1'b1;
         wait_cyc(5);
      end
      wait_cyc(30);
      chk("glitch_no_chg", chg_cnt, base_chg);
      chk("glitch_mode", 32'(mode), 1);
      BTN0 = 1'b0;
      wait_cyc(16);
      BTN0 = 1'b1;
      wait_cyc(40);
      chk("min_press_chg", chg_cnt, base_chg + 1);
      chk("min_press_mode", 32'(mode), 2);

      // Short BTN1 presses toggle tx_en one cycle after the debounced release.
      base_chg = chg_cnt;
      BTN1 = 1'b0;
      wait_cyc(200);
      r = cyc;
      BTN1 = 1'b1;
      wait_cyc(40);
      chk("short1_tx_en", 32'(tx_en), 1);
      chk("short1_time", last_tx_cyc, r + Lat);
      BTN1 = 1'b0;
      wait_cyc(200);
      BTN1 = 1'b1;
      wait_cyc(40);
      chk("short2_tx_en", 32'(tx_en), 0);
      BTN1 = 1'b0;
      wait_cyc(200);
      BTN1 = 1'b1;
      wait_cyc(40);
      chk("short3_tx_en", 32'(tx_en), 1);
      chk("short_no_abort", abort_cnt, 0);
      chk("short_mode_kept", 32'(mode), 2);
      chk("short_no_chg", chg_cnt, base_chg);

      // Long BTN1 hold with mode=2, tx_en=1.
      base_chg = chg_cnt;
      base_ab  = abort_cnt;
      d = cyc;
      BTN1 = 1'b0;
      wait_cyc(2060);
      chk("long_abort_once", abort_cnt, base_ab + 1);
      chk("long_abort_time", last_abort_cyc, d + Lat + Long);
      chk("long_chg_once", chg_cnt, base_chg + 1);
      chk("long_chg_time", last_chg_cyc, d + Lat + Long);
      chk("long_tx_time", last_tx_cyc, d + Lat + Long);
      chk("long_tx_en", 32'(tx_en), 0);
      chk("long_mode", 32'(mode), 0);
      BTN1 = 1'b1;
      wait_cyc(40);
      chk("long_rel_tx_en", 32'(tx_en), 0);
      chk("long_rel_abort", abort_cnt, base_ab + 1);

      // BTN0 press while BTN1 is held is dropped; BTN1 short press still acts.
      base_chg = chg_cnt;
      BTN1 = 1'b0;
      wait_cyc(100);
      BTN0 = 1'b0;
      wait_cyc(40);
      BTN0 = 1'b1;
      wait_cyc(40);
      BTN1 = 1'b1;
      wait_cyc(40);
      chk("held_b0_mode", 32'(mode), 0);
      chk("held_b0_no_chg", chg_cnt, base_chg);
      chk("held_b1_tx_en", 32'(tx_en), 1);

      // Same-cycle press of both buttons: only BTN1 is taken.
      BTN0 = 1'b0;
      BTN1 = 1'b0;
      wait_cyc(100);
      BTN0 = 1'b1;
      BTN1 = 1'b1;
      wait_cyc(40);
      chk("simul_mode", 32'(mode), 0);
      chk("simul_no_chg", chg_cnt, base_chg);
      chk("simul_tx_en", 32'(tx_en), 0);

      // Reset mid-HELD with BTN1 still low: state discarded, fresh press follows.
      BTN0 = 1'b0;
      wait_cyc(40);
      BTN0 = 1'b1;
      wait_cyc(40);
      chk("pre_rst_mode", 32'(mode), 1);
      BTN1 = 1'b0;
      wait_cyc(200);
      BTN1 = 1'b1;
      wait_cyc(40);
      chk("pre_rst_tx_en", 32'(tx_en), 1);
      BTN1 = 1'b0;
      wait_cyc(100);
      RSTBTN = 1'b0;
      wait_cyc(5);
      chk("midrst_mode", 32'(mode), 0);
      chk("midrst_tx_en", 32'(tx_en), 0);
      base_chg = chg_cnt;
      base_ab  = abort_cnt;
      RSTBTN = 1'b1;
      d = cyc;
      wait_cyc(1100);
      chk("postrst_abort", abort_cnt, base_ab + 1);
      chk("postrst_abort_time", last_abort_cyc, d + Lat + Long);
      chk("postrst_no_chg", chg_cnt, base_chg);
      BTN1 = 1'b1;
      wait_cyc(40);
      chk("postrst_tx_en", 32'(tx_en), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
